hvac_zone_scheduler: RTL and testbench

- Shares one heating/cooling plant (same hysteresis thresholds as the single-zone AC block) between ZONES independent temperature zones.
- Grants the plant to one zone at a time, round-robin.
- Enforces minimum run time and a post-run dwell (compressor protection).
- Drives the plant's heating/cooling enables and a one-hot zone-valve grant.

---
 rtl/hvac_zone_scheduler.sv | 140 ++++++++++++++
 tb/tb_hvac_zone_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hvac_zone_scheduler.sv
// Round-robin scheduler sharing one heat/cool plant between ZONES zones, with minimum run and dwell.
// Optional preemption after MAX_RUN cycles is enabled by defining HVAC_PREEMPT_EN.
module hvac_zone_scheduler #(
    parameter int ZONES    = 4,
    parameter int TW       = 5,
    parameter int LOW      = 18,
    parameter int HIGH     = 22,
    parameter int SETPOINT = 20,
    parameter int MIN_RUN  = 8,
    parameter int MAX_RUN  = 32,
    parameter int DWELL    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ZONES*TW-1:0]   temperature,
    input  logic [ZONES-1:0]      zone_en,
    output logic                  heating,
    output logic                  cooling,
    output logic [ZONES-1:0]      grant,
    output logic                  busy
);

    localparam int PW   = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int CMAX = (MAX_RUN > DWELL) ? MAX_RUN : DWELL;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [TW-1:0] LOW_T      = TW'(LOW);
    localparam logic [TW-1:0] HIGH_T     = TW'(HIGH);
    localparam logic [TW-1:0] SETPOINT_T = TW'(SETPOINT);
    localparam logic [CW-1:0] MIN_RUN_C  = CW'(MIN_RUN);
    localparam logic [CW-1:0] DWELL_C    = CW'(DWELL);
`ifdef HVAC_PREEMPT_EN
    localparam logic [CW-1:0] MAX_RUN_C  = CW'(MAX_RUN);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_HEAT, ST_COOL, ST_DWELL} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   rr_ptr, next_rr;
    logic [CW-1:0]   run_cnt, next_run;
    logic [CW-1:0]   dwell_cnt, next_dwell;
    logic [ZONES-1:0] next_grant;

    logic [TW-1:0]   zone_temp [ZONES];
    logic [ZONES-1:0] heat_req, cool_req, demand;
    logic            found;
    logic [PW-1:0]   pick;
    logic            satisfied;
    logic            release_run;

    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            zone_temp[i] = temperature[i*TW +: TW];
            heat_req[i]  = zone_en[i] && (zone_temp[i] < LOW_T);
            cool_req[i]  = zone_en[i] && (zone_temp[i] > HIGH_T);
        end
        demand = heat_req | cool_req;
    end

    // rr_ptr holds the last granted zone, so the search starts just past it.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 1; k <= ZONES; k++) begin
            if (!found && demand[(int'(rr_ptr) + k) % ZONES]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr) + k) % ZONES);
            end
        end
    end

    always_comb begin
        satisfied = (state == ST_HEAT) ? (zone_temp[rr_ptr] >= SETPOINT_T)
                                       : (zone_temp[rr_ptr] <= SETPOINT_T);
        release_run = (run_cnt >= MIN_RUN_C) && (satisfied || !zone_en[rr_ptr]);
`ifdef HVAC_PREEMPT_EN
        if ((run_cnt >= MAX_RUN_C) && |(demand & ~(ZONES'(1) << rr_ptr)))
            release_run = 1'b1;
`endif
    end

    always_comb begin
        next_state = state;
        next_rr    = rr_ptr;
        next_run   = run_cnt;
        next_dwell = dwell_cnt;
        next_grant = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    next_state = heat_req[pick] ? ST_HEAT : ST_COOL;
                    next_grant = ZONES'(1) << pick;
                    next_rr    = pick;
                    next_run   = CW'(1);
                end
            end
            ST_HEAT, ST_COOL: begin
                next_grant = grant;
                if (run_cnt != '1)
                    next_run = run_cnt + 1'b1;
                if (release_run) begin
                    next_state = ST_DWELL;
                    next_grant = '0;
                    next_dwell = CW'(1);
                end
            end
            ST_DWELL: begin
                if (dwell_cnt >= DWELL_C)
                    next_state = ST_IDLE;
                else
                    next_dwell = dwell_cnt + 1'b1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= PW'(ZONES - 1);
            run_cnt   <= '0;
            dwell_cnt <= '0;
            heating   <= 1'b0;
            cooling   <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            rr_ptr    <= next_rr;
            run_cnt   <= next_run;
            dwell_cnt <= next_dwell;
            heating   <= (next_state == ST_HEAT);
            cooling   <= (next_state == ST_COOL);
            grant     <= next_grant;
            busy      <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Self-checking bench for hvac_zone_scheduler: directed scenarios plus random temperatures,
// all compared each cycle against a phase-based reference model.
module tb_hvac_zone_scheduler;

    localparam int ZONES    = 4;
    localparam int TW       = 5;
    localparam int LOW      = 18;
    localparam int HIGH     = 22;
    localparam int SETPOINT = 20;
    localparam int MIN_RUN  = 8;
    localparam int MAX_RUN  = 32;
    localparam int DWELL    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [ZONES*TW-1:0] temperature;
    logic [ZONES-1:0]    zone_en;
    logic                heating, cooling, busy;
    logic [ZONES-1:0]    grant;
    logic [TW-1:0]       temp_arr [ZONES];

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 heating, 2 cooling, 3 plant-off gap
    int m_phase, m_zone, m_last, m_run, m_left;

    for (genvar g = 0; g < ZONES; g++) begin : g_pack
        assign temperature[g*TW +: TW] = temp_arr[g];
    end

    hvac_zone_scheduler #(
        .ZONES(ZONES), .TW(TW), .LOW(LOW), .HIGH(HIGH), .SETPOINT(SETPOINT),
        .MIN_RUN(MIN_RUN), .MAX_RUN(MAX_RUN), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst(rst), .temperature(temperature), .zone_en(zone_en),
        .heating(heating), .cooling(cooling), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_phase = 0;
        m_zone  = 0;
        m_last  = ZONES - 1;
        m_run   = 0;
        m_left  = 0;
    endtask

    function automatic bit wantsHeat(int z);
        return zone_en[z] && (int'(temp_arr[z]) < LOW);
    endfunction

    function automatic bit wantsCool(int z);
        return zone_en[z] && (int'(temp_arr[z]) > HIGH);
    endfunction

    task automatic modelStep();
        bit chosen, done, others;
        int z;
        chosen = 0;
        case (m_phase)
            0: begin
                for (int k = 1; k <= ZONES; k++) begin
                    z = (m_last + k) % ZONES;
                    if (!chosen && (wantsHeat(z) || wantsCool(z))) begin
                        chosen  = 1;
                        m_phase = wantsHeat(z) ? 1 : 2;
                        m_zone  = z;
                        m_last  = z;
                        m_run   = 1;
                    end
                end
            end
            1, 2: begin
                done = (m_phase == 1) ? (int'(temp_arr[m_zone]) >= SETPOINT)
                                      : (int'(temp_arr[m_zone]) <= SETPOINT);
                done = (m_run >= MIN_RUN) && (done || !zone_en[m_zone]);
                others = 0;
                for (int k = 0; k < ZONES; k++)
                    if (k != m_zone && (wantsHeat(k) || wantsCool(k))) others = 1;
`ifdef HVAC_PREEMPT_EN
                if (m_run >= MAX_RUN && others) done = 1;
`endif
                if (done) begin
                    m_phase = 3;
                    m_left  = DWELL;
                end else begin
                    m_run++;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic compareAll(input string tag);
        logic [31:0] exp_grant;
        exp_grant = (m_phase == 1 || m_phase == 2) ? (32'd1 << m_zone) : 32'd0;
        checkOutput({tag, ".heating"}, 32'(heating), 32'(m_phase == 1));
        checkOutput({tag, ".cooling"}, 32'(cooling), 32'(m_phase == 2));
        checkOutput({tag, ".grant"}, 32'(grant), exp_grant);
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_phase != 0));
    endtask

    // Runs n clock cycles starting from a falling edge, checking every cycle.
    task automatic applyStimulus(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            modelStep();
            #1;
            compareAll(tag);
            @(negedge clk);
        end
    endtask

    task automatic randomInputs();
        for (int i = 0; i < ZONES; i++) begin
            if ($urandom_range(0, 5) == 0) temp_arr[i] = TW'($urandom_range(8, 31));
            if ($urandom_range(0, 29) == 0) zone_en[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic setAllTemps(input int t);
        for (int i = 0; i < ZONES; i++) temp_arr[i] = TW'(t);
    endtask

    initial begin
        rst = 1'b1;
        zone_en = '1;
        setAllTemps(20);
        modelReset();
        #1;
        compareAll("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(20, "idle");

        temp_arr[0] = 15;
        applyStimulus(3, "minrun");
        temp_arr[0] = 20;
        applyStimulus(20, "minrun");

        temp_arr[1] = 25;
        temp_arr[2] = 10;
        applyStimulus(12, "rr");
        temp_arr[1] = 20;
        applyStimulus(20, "rr");
        temp_arr[2] = 20;
        applyStimulus(20, "rr");

        temp_arr[3] = 10;
        zone_en[3] = 1'b0;
        applyStimulus(5, "mask");
        zone_en[3] = 1'b1;
        applyStimulus(12, "mask");
        zone_en[3] = 1'b0;
        applyStimulus(10, "mask");
        temp_arr[3] = 20;
        zone_en = '1;
        applyStimulus(10, "mask");

        temp_arr[0] = 10;
        temp_arr[1] = 10;
        applyStimulus(60, "preempt");
        setAllTemps(20);
        applyStimulus(40, "preempt");

        temp_arr[0] = 10;
        temp_arr[3] = 10;
        applyStimulus(3, "midreset");
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        compareAll("asyncreset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(20, "midreset");
        setAllTemps(20);
        applyStimulus(40, "midreset");

        for (int c = 0; c < 2000; c++) begin
            randomInputs();
            applyStimulus(1, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
